// File: rtl/lc3_ctrl_fsm.sv
// Multi-cycle control sequencer for the LC-3-style core: walks each instruction
// through fetch/decode/execute/indirect/memory phases and owns the shared memory port.
module lc3_ctrl_fsm #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic [3:0]       opcode,
  input  logic             ir11,
  input  logic             br_taken,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       mem_addr_sel,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic [1:0]       reg_wr_sel,
  output logic             cc_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal_op,
  output logic             bus_err,
  output logic [CNT_W-1:0] inst_count
);

  // Memory handshake: mem_req is held until the cycle mem_ack is seen with it;
  // mem_ack without mem_req is ignored. Reset (rst_n=1) suppresses every request and strobe.

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_IND    = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);
  localparam bit WD_ON = (TIMEOUT != 0);

  localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011,
                         OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
                         OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                         OP_LEA = 4'b1110, OP_TRAP = 4'b1111;

  state_t            cur, nxt;
  logic              req_pend;
  logic              mem_store_q, mem_ind_q;
  logic [WD_W-1:0]   wd_cnt;
  logic              bus_err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_raw, ack, wd_expire, retire;
  logic              latch_mem, nxt_store, nxt_ind;

  always_comb begin
    req_raw = 1'b0;
    case (cur)
      S_FETCH:      req_raw = run_en | req_pend;
      S_IND, S_MEM: req_raw = 1'b1;
      default:      req_raw = 1'b0;
    endcase
  end

  assign mem_req   = req_raw & ~rst_n;
  assign ack       = mem_req & mem_ack;
  assign wd_expire = WD_ON && mem_req && !mem_ack && (wd_cnt == WD_LAST);

  always_comb begin
    nxt          = cur;
    mem_we       = 1'b0;
    mem_addr_sel = 2'd0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    reg_we       = 1'b0;
    reg_wr_sel   = 2'd0;
    cc_we        = 1'b0;
    illegal_op   = 1'b0;
    retire       = 1'b0;
    latch_mem    = 1'b0;
    nxt_store    = 1'b0;
    nxt_ind      = 1'b0;
    case (cur)
      S_FETCH: begin
        if (ack) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        nxt = S_FETCH;
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            reg_we = 1'b1;
            cc_we  = 1'b1;
            retire = 1'b1;
          end
          OP_LEA: begin
            reg_we = 1'b1;
            retire = 1'b1;
          end
          OP_BR: begin
            pc_we  = br_taken;
            pc_sel = 2'd1;
            retire = 1'b1;
          end
          OP_JMP: begin
            pc_we  = 1'b1;
            pc_sel = 2'd2;
            retire = 1'b1;
          end
          OP_JSR: begin
            // R7 captures the old PC in the same cycle the PC is redirected
            reg_we     = 1'b1;
            reg_wr_sel = 2'd2;
            pc_we      = 1'b1;
            pc_sel     = ir11 ? 2'd1 : 2'd2;
            retire     = 1'b1;
          end
          OP_LD, OP_LDR, OP_ST, OP_STR: begin
            latch_mem = 1'b1;
            nxt_store = opcode[0];
            nxt       = S_MEM;
          end
          OP_LDI, OP_STI: begin
            latch_mem = 1'b1;
            nxt_store = opcode[0];
            nxt_ind   = 1'b1;
            nxt       = S_IND;
          end
          OP_TRAP: begin
            retire = 1'b1;
            nxt    = S_HALT;
          end
          default: begin
            illegal_op = 1'b1;
            nxt        = S_HALT;
          end
        endcase
      end
      S_IND: begin
        mem_addr_sel = 2'd1;
        if (ack) begin
          mdr_we = 1'b1;
          nxt    = S_MEM;
        end
      end
      S_MEM: begin
        mem_addr_sel = mem_ind_q ? 2'd2 : 2'd1;
        mem_we       = mem_store_q;
        if (ack) begin
          reg_we     = ~mem_store_q;
          reg_wr_sel = mem_store_q ? 2'd0 : 2'd1;
          cc_we      = ~mem_store_q;
          retire     = 1'b1;
          nxt        = S_FETCH;
        end
      end
      default: nxt = S_HALT;
    endcase
    if (wd_expire) nxt = S_HALT;
    if (rst_n) begin
      mem_we       = 1'b0;
      mem_addr_sel = 2'd0;
      ir_we        = 1'b0;
      mdr_we       = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 2'd0;
      reg_we       = 1'b0;
      reg_wr_sel   = 2'd0;
      cc_we        = 1'b0;
      illegal_op   = 1'b0;
      retire       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) cur <= S_FETCH;
    else       cur <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      req_pend    <= 1'b0;
      mem_store_q <= 1'b0;
      mem_ind_q   <= 1'b0;
      wd_cnt      <= '0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      req_pend <= (cur == S_FETCH) && mem_req && !mem_ack && !wd_expire;
      wd_cnt   <= (mem_req && !mem_ack) ? wd_cnt + WD_W'(1) : '0;
      if (wd_expire) bus_err_q <= 1'b1;
      if (retire)    cnt_q     <= cnt_q + CNT_W'(1);
      if (latch_mem) begin
        mem_store_q <= nxt_store;
        mem_ind_q   <= nxt_ind;
      end
    end
  end

  assign state      = cur;
  assign halted     = (cur == S_HALT) & ~rst_n;
  assign bus_err    = bus_err_q;
  assign inst_count = cnt_q;

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Bench for lc3_ctrl_fsm: table of instruction vectors, random instruction stream
// checked against an instruction-level model, and hand sequences for timeout/reset/wrap.
module tb_lc3_ctrl_fsm;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int P_RET = 0, P_MEM = 1, P_IND = 2, P_TRAP = 3, P_ILL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic run_en = 1'b0, ir11 = 1'b0, br_taken = 1'b0, mem_ack = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic mem_req, mem_we, ir_we, mdr_we, pc_we, reg_we, cc_we, halted, illegal_op, bus_err;
  logic [1:0] mem_addr_sel, pc_sel, reg_wr_sel;
  logic [2:0] state;
  logic [CNT_W-1:0] inst_count;

  typedef struct packed {
    logic       req;
    logic       we;
    logic [1:0] asel;
    logic       ir;
    logic       mdr;
    logic       pc;
    logic [1:0] psel;
    logic       rw;
    logic [1:0] wsel;
    logic       cc;
    logic [2:0] st;
    logic       halt;
    logic       ill;
    logic       berr;
  } outs_t;

  // ex = {reg_we, reg_wr_sel, cc_we, pc_we, pc_sel, illegal_op} seen in the execute cycle
  typedef struct {
    logic [3:0] op;
    logic       i11;
    logic       br;
    int         dly;
    logic [7:0] ex;
    int         path;
  } vec_t;

  outs_t act;
  int n_cmp = 0, n_err = 0, exp_retired = 0;
  logic [CNT_W-1:0] exp_q[$];
  vec_t tbl[15];

  lc3_ctrl_fsm #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .opcode(opcode), .ir11(ir11),
    .br_taken(br_taken), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .reg_we(reg_we), .reg_wr_sel(reg_wr_sel), .cc_we(cc_we),
    .state(state), .halted(halted), .illegal_op(illegal_op), .bus_err(bus_err),
    .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, pc_sel, reg_we,
                reg_wr_sel, cc_we, state, halted, illegal_op, bus_err};

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, limit 500000 time units");
    $fatal(1);
  end

  // Compare 1 time unit into the cycle, then move to 1 unit after the next edge.
  task automatic chk(input string name, input outs_t e);
    #1;
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_cnt(input string name);
    logic [CNT_W-1:0] e;
    exp_q.push_back(CNT_W'(exp_retired % (1 << CNT_W)));
    e = exp_q.pop_front();
    n_cmp++;
    if (inst_count !== e) begin
      n_err++;
      $display("FAIL %s: inst_count got %0d, expected %0d", name, inst_count, e);
    end
  endtask

  task automatic do_reset();
    outs_t e;
    rst_n = 1'b1; run_en = 1'b0; mem_ack = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    exp_retired = 0;
    e = '0;
    chk_cnt("reset_count");
    chk("reset_state", e);
  endtask

  // Instruction-level reference: what the execute cycle does and where it goes next.
  function automatic void model(input logic [3:0] op, input logic i11, input logic br,
                                output logic [7:0] ex, output int path);
    ex = 8'h00; path = P_RET;
    case (op)
      4'b0001, 4'b0101, 4'b1001: ex = {1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0};
      4'b1110:                   ex = {1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
      4'b0000:                   ex = {1'b0, 2'd0, 1'b0, br,   2'd1, 1'b0};
      4'b1100:                   ex = {1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0};
      4'b0100:                   ex = {1'b1, 2'd2, 1'b0, 1'b1, i11 ? 2'd1 : 2'd2, 1'b0};
      4'b0010, 4'b0110, 4'b0011, 4'b0111: path = P_MEM;
      4'b1010, 4'b1011:          path = P_IND;
      4'b1111:                   path = P_TRAP;
      default: begin ex = 8'h01; path = P_ILL; end
    endcase
  endfunction

  task automatic mem_phase(input string name, input int dly, input logic [1:0] asel,
                           input logic we, input logic is_ind, input logic is_load,
                           input logic [2:0] st);
    outs_t e;
    for (int k = 0; k <= dly; k++) begin
      mem_ack = (k == dly);
      e = '0; e.req = 1'b1; e.asel = asel; e.we = we; e.st = st;
      if (k == dly) begin
        e.mdr = is_ind;
        if (is_load) begin e.rw = 1'b1; e.wsel = 2'd1; e.cc = 1'b1; end
      end
      chk(name, e);
    end
    mem_ack = 1'b0;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic i11, input logic br,
                           input int dly, input logic [7:0] ex, input int path);
    outs_t e;
    logic is_store;
    is_store = (op == 4'b0011) || (op == 4'b0111) || (op == 4'b1011);
    opcode = op; ir11 = i11; br_taken = br; run_en = 1'b1;
    for (int k = 0; k <= dly; k++) begin
      mem_ack = (k == dly);
      e = '0; e.req = 1'b1;
      if (k == dly) begin e.ir = 1'b1; e.pc = 1'b1; end
      chk(k == dly ? "fetch_ack" : "fetch_wait", e);
      run_en = 1'(($urandom_range(0, 1)));
    end
    run_en = 1'b0;
    mem_ack = 1'(($urandom_range(0, 1)));
    e = '0; e.st = 3'd1;
    chk("decode", e);
    mem_ack = 1'(($urandom_range(0, 1)));
    e = '0; e.st = 3'd2;
    {e.rw, e.wsel, e.cc, e.pc, e.psel, e.ill} = ex;
    chk("exec", e);
    mem_ack = 1'b0;
    if (path == P_RET || path == P_TRAP) exp_retired++;
    if (path == P_IND) mem_phase("ind", dly, 2'd1, 1'b0, 1'b1, 1'b0, 3'd3);
    if (path == P_MEM || path == P_IND) begin
      mem_phase("mem", dly, (path == P_IND) ? 2'd2 : 2'd1, is_store, 1'b0, !is_store, 3'd4);
      exp_retired++;
    end
    if (path == P_TRAP || path == P_ILL) begin
      run_en = 1'b1; mem_ack = 1'b1;
      e = '0; e.st = 3'd5; e.halt = 1'b1;
      chk("halt", e);
      chk("halt_hold", e);
    end
    chk_cnt("retired");
  endtask

  initial begin
    outs_t e;
    logic [7:0] ex;
    int path;
    logic [3:0] op;
    logic [3:0] pool[14];

    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 2, 8'b1_00_1_0_00_0, P_RET};
    tbl[1]  = '{4'b0101, 1'b0, 1'b0, 0, 8'b1_00_1_0_00_0, P_RET};
    tbl[2]  = '{4'b1001, 1'b0, 1'b0, 1, 8'b1_00_1_0_00_0, P_RET};
    tbl[3]  = '{4'b1110, 1'b0, 1'b0, 0, 8'b1_00_0_0_00_0, P_RET};
    tbl[4]  = '{4'b0000, 1'b0, 1'b0, 0, 8'b0_00_0_0_01_0, P_RET};
    tbl[5]  = '{4'b0000, 1'b0, 1'b1, 1, 8'b0_00_0_1_01_0, P_RET};
    tbl[6]  = '{4'b1100, 1'b0, 1'b0, 0, 8'b0_00_0_1_10_0, P_RET};
    tbl[7]  = '{4'b0100, 1'b1, 1'b0, 0, 8'b1_10_0_1_01_0, P_RET};
    tbl[8]  = '{4'b0100, 1'b0, 1'b0, 2, 8'b1_10_0_1_10_0, P_RET};
    tbl[9]  = '{4'b0010, 1'b0, 1'b0, 1, 8'b0_00_0_0_00_0, P_MEM};
    tbl[10] = '{4'b0011, 1'b0, 1'b0, 0, 8'b0_00_0_0_00_0, P_MEM};
    tbl[11] = '{4'b0110, 1'b0, 1'b0, 3, 8'b0_00_0_0_00_0, P_MEM};
    tbl[12] = '{4'b0111, 1'b0, 1'b0, 2, 8'b0_00_0_0_00_0, P_MEM};
    tbl[13] = '{4'b1010, 1'b0, 1'b0, 0, 8'b0_00_0_0_00_0, P_IND};
    tbl[14] = '{4'b1011, 1'b0, 1'b0, 1, 8'b0_00_0_0_00_0, P_IND};
    pool = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
             4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b0001};

    do_reset();
    for (int i = 0; i < 15; i++)
      run_instr(tbl[i].op, tbl[i].i11, tbl[i].br, tbl[i].dly, tbl[i].ex, tbl[i].path);

    // Randomised instruction stream with idle gaps and stray acks while idle.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) op = ($urandom_range(0, 2) == 0) ? 4'b1111 :
                                          (($urandom_range(0, 1) == 0) ? 4'b1000 : 4'b1101);
      else op = pool[$urandom_range(0, 13)];
      ir11 = 1'(($urandom_range(0, 1)));
      br_taken = 1'(($urandom_range(0, 1)));
      model(op, ir11, br_taken, ex, path);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        run_en = 1'b0; mem_ack = 1'(($urandom_range(0, 1)));
        e = '0;
        chk("idle", e);
      end
      run_instr(op, ir11, br_taken, $urandom_range(0, 3), ex, path);
      if (path == P_TRAP || path == P_ILL) do_reset();
    end

    // Watchdog: no ack in fetch for TIMEOUT request cycles.
    do_reset();
    run_en = 1'b1; mem_ack = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      e = '0; e.req = 1'b1;
      chk("wd_wait", e);
      run_en = 1'b0;
    end
    run_en = 1'b1; mem_ack = 1'b1;
    e = '0; e.st = 3'd5; e.halt = 1'b1; e.berr = 1'b1;
    chk("wd_halt", e);
    chk("wd_sticky", e);
    chk_cnt("wd_count");

    // Reset during a store's memory wait: no strobes that cycle, clean afterwards.
    do_reset();
    run_instr(4'b0001, 1'b0, 1'b0, 0, 8'b1_00_1_0_00_0, P_RET);
    opcode = 4'b0111; run_en = 1'b1; mem_ack = 1'b1;
    e = '0; e.req = 1'b1; e.ir = 1'b1; e.pc = 1'b1;
    chk("str_fetch", e);
    run_en = 1'b0; mem_ack = 1'b0;
    e = '0; e.st = 3'd1; chk("str_decode", e);
    e = '0; e.st = 3'd2; chk("str_exec", e);
    e = '0; e.req = 1'b1; e.we = 1'b1; e.asel = 2'd1; e.st = 3'd4;
    chk("str_mem_wait", e);
    rst_n = 1'b1; mem_ack = 1'b1;
    #1;
    n_cmp++;
    if ({mem_req, ir_we, mdr_we, pc_we, reg_we, cc_we, illegal_op} !== 7'b0) begin
      n_err++;
      $display("FAIL rst_mid_strobes: got %b, expected 0000000",
               {mem_req, ir_we, mdr_we, pc_we, reg_we, cc_we, illegal_op});
    end
    @(posedge clk); #1;
    rst_n = 1'b0; mem_ack = 1'b0; exp_retired = 0;
    e = '0;
    chk_cnt("rst_mid_count");
    chk("rst_mid_after", e);

    // Counter wrap after 2**CNT_W retirements, then an illegal opcode.
    do_reset();
    for (int i = 0; i < (1 << CNT_W); i++)
      run_instr(4'b1001, 1'b0, 1'b0, $urandom_range(0, 1), 8'b1_00_1_0_00_0, P_RET);
    run_instr(4'b1101, 1'b0, 1'b0, 0, 8'b0_00_0_0_00_1, P_ILL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
